// File: rtl/sobel_edge_pkg.sv
// Shared definitions for the Sobel edge stream: output mode encoding,
// grey conversion coefficients and RGB565 <-> 8-bit grey helpers.
package sobel_edge_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GREY = 2'd1,
        MODE_MAG  = 2'd2,
        MODE_BIN  = 2'd3
    } mode_e;

    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // The coefficients sum to 256, so white lands exactly on 255 after the shift.
    function automatic logic [7:0] rgb565_to_y8(input logic [15:0] pix);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] acc;
        r8  = {pix[15:11], pix[15:13]};
        g8  = {pix[10:5], pix[10:9]};
        b8  = {pix[4:0], pix[4:2]};
        acc = 16'(COEF_R) * 16'(r8) + 16'(COEF_G) * 16'(g8) + 16'(COEF_B) * 16'(b8);
        return acc[15:8];
    endfunction

    function automatic logic [15:0] y8_to_rgb565(input logic [7:0] m);
        return {m[7:3], m[7:2], m[7:3]};
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Simple dual-port RAM holding two packed grey rows per column.
// One-cycle read latency; a same-address read and write returns the old word.
module sobel_line_buf #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic          sclk,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_ren,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge sclk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming RGB565 Sobel filter: grey conversion, 3x3 window from two line
// buffers, and a per-frame output mode (pass, grey, magnitude, binary edge).
module sobel_edge_stream
    import sobel_edge_pkg::*;
#(
    parameter int IMG_W = 1024
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [15:0] rx_data,
    input  logic        pi_flag,
    input  logic        pi_sof,
    input  logic [1:0]  i_mode,
    input  logic [7:0]  i_thresh,
    output logic [15:0] tx_data,
    output logic [15:0] o_grey_data,
    output logic        po_flag
);

    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    function automatic logic signed [10:0] sx(input logic [7:0] v);
        return $signed({3'b000, v});
    endfunction

    logic [CW-1:0] r_col;
    logic [1:0]    r_row;
    mode_e         r_frameMode;
    logic [7:0]    r_frameThresh;

    logic [CW-1:0] w_col;
    logic [1:0]    w_row;
    mode_e         w_mode;
    logic [7:0]    w_thresh;

    logic          r_s1Valid, r_s2Valid, r_s3Valid, r_s4Valid;
    logic [15:0]   r_s1Data, r_s2Data, r_s3Data, r_s4Data;
    logic [CW-1:0] r_s1Col, r_s2Col;
    logic [1:0]    r_s1Row, r_s2Row;
    mode_e         r_s1Mode, r_s2Mode, r_s3Mode, r_s4Mode;
    logic [7:0]    r_s1Thresh, r_s2Thresh, r_s3Thresh, r_s4Thresh;
    logic [7:0]    r_s2Y, r_s3Y, r_s4Y;
    logic          r_s3Border, r_s4Border;
    logic [7:0]    w_s1Y;

    logic [15:0]   w_lbRdData, w_lbData, w_lbWrData;
    logic          r_bypass;
    logic [15:0]   r_bypassData;

    logic [2:0][2:0][7:0] r_win;
    logic signed [10:0]   w_gx, w_gy, r_s4Gx, r_s4Gy;
    logic [10:0]          w_absX, w_absY;
    logic [11:0]          w_sum;
    logic [7:0]           w_mag;
    logic [15:0]          w_txNext;

    logic [15:0] r_txData, r_greyData;
    logic        r_poFlag;

    // An SOF pixel restarts the raster and supplies the mode for itself.
    assign w_col    = pi_sof ? '0 : r_col;
    assign w_row    = pi_sof ? 2'd0 : r_row;
    assign w_mode   = pi_sof ? mode_e'(i_mode) : r_frameMode;
    assign w_thresh = pi_sof ? i_thresh : r_frameThresh;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_col         <= '0;
            r_row         <= 2'd0;
            r_frameMode   <= MODE_PASS;
            r_frameThresh <= 8'd0;
        end else if (pi_flag) begin
            r_frameMode   <= w_mode;
            r_frameThresh <= w_thresh;
            if (w_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Data   <= 16'd0;
            r_s1Col    <= '0;
            r_s1Row    <= 2'd0;
            r_s1Mode   <= MODE_PASS;
            r_s1Thresh <= 8'd0;
        end else begin
            r_s1Valid <= pi_flag;
            if (pi_flag) begin
                r_s1Data   <= rx_data;
                r_s1Col    <= w_col;
                r_s1Row    <= w_row;
                r_s1Mode   <= w_mode;
                r_s1Thresh <= w_thresh;
            end
        end
    end

    assign w_s1Y = rgb565_to_y8(r_s1Data);

    // Back-to-back pixels on the same column (SOF right after col 0) would read
    // the word still being written, so forward the write data instead.
    assign w_lbData   = r_bypass ? r_bypassData : w_lbRdData;
    assign w_lbWrData = {w_lbData[7:0], r_s2Y};

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .AW    (CW),
        .DW    (16)
    ) u_line_buf (
        .sclk    (sclk),
        .i_wen   (r_s2Valid),
        .i_waddr (r_s2Col),
        .i_wdata (w_lbWrData),
        .i_ren   (r_s1Valid),
        .i_raddr (r_s1Col),
        .o_rdata (w_lbRdData)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_s2Valid    <= 1'b0;
            r_s2Data     <= 16'd0;
            r_s2Y        <= 8'd0;
            r_s2Col      <= '0;
            r_s2Row      <= 2'd0;
            r_s2Mode     <= MODE_PASS;
            r_s2Thresh   <= 8'd0;
            r_bypass     <= 1'b0;
            r_bypassData <= 16'd0;
        end else begin
            r_s2Valid    <= r_s1Valid;
            r_bypass     <= r_s1Valid && r_s2Valid && (r_s1Col == r_s2Col);
            r_bypassData <= w_lbWrData;
            if (r_s1Valid) begin
                r_s2Data   <= r_s1Data;
                r_s2Y      <= w_s1Y;
                r_s2Col    <= r_s1Col;
                r_s2Row    <= r_s1Row;
                r_s2Mode   <= r_s1Mode;
                r_s2Thresh <= r_s1Thresh;
            end
        end
    end

    // Window rows: 0 = two lines up, 1 = one line up, 2 = current line.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_win      <= '0;
            r_s3Valid  <= 1'b0;
            r_s3Data   <= 16'd0;
            r_s3Y      <= 8'd0;
            r_s3Mode   <= MODE_PASS;
            r_s3Thresh <= 8'd0;
            r_s3Border <= 1'b0;
        end else begin
            r_s3Valid <= r_s2Valid;
            if (r_s2Valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lbData[15:8];
                r_win[1][2] <= w_lbData[7:0];
                r_win[2][2] <= r_s2Y;
                r_s3Data    <= r_s2Data;
                r_s3Y       <= r_s2Y;
                r_s3Mode    <= r_s2Mode;
                r_s3Thresh  <= r_s2Thresh;
                r_s3Border  <= (r_s2Row < 2'd2) || (r_s2Col < CW'(2));
            end
        end
    end

    assign w_gx = (sx(r_win[0][2]) + (sx(r_win[1][2]) <<< 1) + sx(r_win[2][2]))
                - (sx(r_win[0][0]) + (sx(r_win[1][0]) <<< 1) + sx(r_win[2][0]));
    assign w_gy = (sx(r_win[2][0]) + (sx(r_win[2][1]) <<< 1) + sx(r_win[2][2]))
                - (sx(r_win[0][0]) + (sx(r_win[0][1]) <<< 1) + sx(r_win[0][2]));

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_s4Valid  <= 1'b0;
            r_s4Data   <= 16'd0;
            r_s4Y      <= 8'd0;
            r_s4Mode   <= MODE_PASS;
            r_s4Thresh <= 8'd0;
            r_s4Border <= 1'b0;
            r_s4Gx     <= '0;
            r_s4Gy     <= '0;
        end else begin
            r_s4Valid <= r_s3Valid;
            if (r_s3Valid) begin
                r_s4Data   <= r_s3Data;
                r_s4Y      <= r_s3Y;
                r_s4Mode   <= r_s3Mode;
                r_s4Thresh <= r_s3Thresh;
                r_s4Border <= r_s3Border;
                r_s4Gx     <= w_gx;
                r_s4Gy     <= w_gy;
            end
        end
    end

    always_comb begin
        w_absX   = r_s4Gx[10] ? 11'(-r_s4Gx) : 11'(r_s4Gx);
        w_absY   = r_s4Gy[10] ? 11'(-r_s4Gy) : 11'(r_s4Gy);
        w_sum    = {1'b0, w_absX} + {1'b0, w_absY};
        w_mag    = 8'd0;
        w_txNext = r_s4Data;
        if (!r_s4Border) begin
            w_mag = (|w_sum[11:8]) ? 8'hFF : w_sum[7:0];
        end
        case (r_s4Mode)
            MODE_PASS: w_txNext = r_s4Data;
            MODE_GREY: w_txNext = y8_to_rgb565(r_s4Y);
            MODE_MAG:  w_txNext = y8_to_rgb565(w_mag);
            MODE_BIN:  w_txNext = (w_mag > r_s4Thresh) ? 16'hFFFF : 16'h0000;
            default:   w_txNext = r_s4Data;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_poFlag   <= 1'b0;
            r_txData   <= 16'd0;
            r_greyData <= 16'd0;
        end else begin
            r_poFlag <= r_s4Valid;
            if (r_s4Valid) begin
                r_txData   <= w_txNext;
                r_greyData <= y8_to_rgb565(r_s4Y);
            end
        end
    end

    assign tx_data     = r_txData;
    assign o_grey_data = r_greyData;
    assign po_flag     = r_poFlag;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream: a frame-level reference model queues
// expected pixels, and a negedge monitor pops and compares each po_flag pulse.
module tb_sobel_edge_stream;
    import sobel_edge_pkg::*;

    localparam int W = 8;
    localparam int PAT_WHITE  = 0;
    localparam int PAT_SPLIT  = 1;
    localparam int PAT_RANDOM = 2;

    logic        sclk = 1'b0;
    logic        rst;
    logic [15:0] rx_data;
    logic        pi_flag;
    logic        pi_sof;
    logic [1:0]  i_mode;
    logic [7:0]  i_thresh;
    logic [15:0] tx_data;
    logic [15:0] o_grey_data;
    logic        po_flag;

    sobel_edge_stream #(.IMG_W(W)) dut (
        .sclk        (sclk),
        .rst         (rst),
        .rx_data     (rx_data),
        .pi_flag     (pi_flag),
        .pi_sof      (pi_sof),
        .i_mode      (i_mode),
        .i_thresh    (i_thresh),
        .tx_data     (tx_data),
        .o_grey_data (o_grey_data),
        .po_flag     (po_flag)
    );

    always #5 sclk = ~sclk;

    int edgeCount = 0;
    always @(posedge sclk) edgeCount++;

    typedef struct {
        int tx;
        int grey;
        int due;
    } exp_t;
    exp_t expQ[$];

    int nChecks = 0;
    int nFails  = 0;

    // Reference state: raster position, frame settings, two stored grey rows
    // and the last three window columns (each column = {two up, one up, current}).
    int mCol, mRow, mMode, mThresh;
    int lbTop[W];
    int lbMid[W];
    int winCol[3][3];

    task automatic checkOutput(input string name, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int greyOf(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    function automatic int expand565(input int m);
        return ((m / 8) * 2048) + ((m / 4) * 32) + (m / 8);
    endfunction

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic modelReset();
        mCol = 0; mRow = 0; mMode = 0; mThresh = 0;
    endtask

    task automatic modelPixel(input logic [15:0] data, input bit sof, input int mode, input int thresh);
        int y, top, mid, gx, gy, mag, tx;
        exp_t e;
        if (sof) begin
            mCol = 0; mRow = 0; mMode = mode; mThresh = thresh;
        end
        y   = greyOf(data);
        top = lbTop[mCol];
        mid = lbMid[mCol];
        lbTop[mCol] = mid;
        lbMid[mCol] = y;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                winCol[c][r] = winCol[c + 1][r];
        winCol[2][0] = top;
        winCol[2][1] = mid;
        winCol[2][2] = y;
        if (mRow < 2 || mCol < 2) begin
            mag = 0;
        end else begin
            gx  = (winCol[2][0] + 2 * winCol[2][1] + winCol[2][2])
                - (winCol[0][0] + 2 * winCol[0][1] + winCol[0][2]);
            gy  = (winCol[0][2] + 2 * winCol[1][2] + winCol[2][2])
                - (winCol[0][0] + 2 * winCol[1][0] + winCol[2][0]);
            mag = absInt(gx) + absInt(gy);
            if (mag > 255) mag = 255;
        end
        case (mMode)
            0:       tx = int'(data);
            1:       tx = expand565(y);
            2:       tx = expand565(mag);
            default: tx = (mag > mThresh) ? 16'hFFFF : 0;
        endcase
        e.tx   = tx;
        e.grey = expand565(y);
        e.due  = edgeCount + 5;
        expQ.push_back(e);
        if (mCol == W - 1) begin
            mCol = 0;
            if (mRow < 2) mRow++;
        end else begin
            mCol++;
        end
    endtask

    // Called half a step after a rising edge; leaves pi_flag low on return.
    task automatic applyStimulus(input logic [15:0] data, input bit sof, input int mode,
                                 input int thresh, input int gap);
        rx_data  = data;
        pi_sof   = sof;
        i_mode   = 2'(mode);
        i_thresh = 8'(thresh);
        pi_flag  = 1'b1;
        modelPixel(data, sof, mode, thresh);
        @(posedge sclk); #1;
        for (int g = 0; g < gap; g++) begin
            pi_flag  = 1'b0;
            pi_sof   = 1'($urandom_range(0, 1));
            i_mode   = 2'($urandom_range(0, 3));
            i_thresh = 8'($urandom_range(0, 255));
            rx_data  = 16'($urandom_range(0, 65535));
            @(posedge sclk); #1;
        end
        pi_flag = 1'b0;
        pi_sof  = 1'b0;
    endtask

    task automatic sendFrame(input bit firstSof, input int mode, input int thresh, input int nPix,
                             input int pat, input int maxGap, input int laterMode);
        logic [15:0] d;
        int col;
        for (int k = 0; k < nPix; k++) begin
            col = k % W;
            case (pat)
                PAT_WHITE: d = 16'hFFFF;
                PAT_SPLIT: d = (col < 4) ? 16'h0000 : 16'hFFFF;
                default:   d = 16'($urandom_range(0, 65535));
            endcase
            applyStimulus(d, (k == 0) && firstSof, (k == 0) ? mode : laterMode,
                          (k == 0) ? thresh : int'($urandom_range(0, 255)),
                          int'($urandom_range(0, maxGap)));
        end
    endtask

    task automatic midReset();
        pi_flag = 1'b0;
        pi_sof  = 1'b0;
        rst     = 1'b1;
        expQ.delete();
        modelReset();
        #1;
        checkOutput("rstPoFlag", int'(po_flag), 0);
        checkOutput("rstTxData", int'(tx_data), 0);
        checkOutput("rstGreyData", int'(o_grey_data), 0);
        repeat (3) @(posedge sclk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge sclk) begin
        exp_t e;
        if (!rst) begin
            if (po_flag) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedPoFlag", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("txData", int'(tx_data), e.tx);
                    checkOutput("greyData", int'(o_grey_data), e.grey);
                    checkOutput("latencyEdge", edgeCount, e.due);
                end
            end else if (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
                e = expQ.pop_front();
                checkOutput("missingPoFlag", 0, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        pi_flag  = 1'b0;
        pi_sof   = 1'b0;
        rx_data  = 16'd0;
        i_mode   = 2'd0;
        i_thresh = 8'd0;
        for (int c = 0; c < W; c++) begin
            lbTop[c] = 0;
            lbMid[c] = 0;
        end
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                winCol[c][r] = 0;
        modelReset();
        repeat (3) @(posedge sclk);
        #1;
        checkOutput("resetPoFlag", int'(po_flag), 0);
        checkOutput("resetTxData", int'(tx_data), 0);
        checkOutput("resetGreyData", int'(o_grey_data), 0);
        rst = 1'b0;
        @(posedge sclk); #1;

        $display("[TB] uniform white frames, magnitude then passthrough");
        sendFrame(1, MODE_MAG, 0, 4 * W, PAT_WHITE, 0, MODE_MAG);
        sendFrame(1, MODE_PASS, 0, 4 * W, PAT_WHITE, 0, MODE_PASS);

        $display("[TB] vertical edge frame, magnitude and binary");
        sendFrame(1, MODE_MAG, 0, 4 * W, PAT_SPLIT, 0, MODE_MAG);
        sendFrame(1, MODE_BIN, 254, 4 * W, PAT_SPLIT, 0, MODE_BIN);
        sendFrame(1, MODE_BIN, 255, 4 * W, PAT_SPLIT, 0, MODE_BIN);

        $display("[TB] vertical edge frame with idle gaps");
        sendFrame(1, MODE_MAG, 0, 4 * W, PAT_SPLIT, 3, MODE_MAG);

        $display("[TB] mode change mid-frame is deferred to the next SOF");
        sendFrame(1, MODE_MAG, 0, 4 * W, PAT_SPLIT, 1, MODE_GREY);
        sendFrame(1, MODE_GREY, 0, 2 * W, PAT_SPLIT, 0, MODE_MAG);

        $display("[TB] randomized frames with partial lines and gaps");
        for (int f = 0; f < 6; f++) begin
            sendFrame(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                      int'($urandom_range(10, 40)), PAT_RANDOM, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] reset mid-frame");
        sendFrame(1, MODE_PASS, 0, 13, PAT_RANDOM, 0, MODE_PASS);
        midReset();
        sendFrame(0, MODE_MAG, 0, 10, PAT_RANDOM, 0, MODE_MAG);
        sendFrame(1, MODE_MAG, 0, 4 * W, PAT_RANDOM, 0, MODE_MAG);

        repeat (20) @(posedge sclk);
        #1;
        checkOutput("drainQueueEmpty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sobel_edge_stream.md
# sobel_edge_stream

Parametrised successor to the fixed RGB565 Sobel path. Accepts a raster stream of RGB565 pixels with a per-pixel valid strobe and a start-of-frame marker, converts each pixel to 8-bit grey, and builds a 3x3 window from two internal line buffers. Each accepted pixel produces exactly one RGB565 output pixel. The output is selected per frame from four modes: passthrough, grey, Sobel magnitude, or thresholded binary edge. It sits between the video input FIFO and the frame-buffer writer.

## Interface
- IMG_W, 1024, active pixels per line; line-buffer depth; column counter width is $clog2(IMG_W)
- sclk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  16  RGB565 input pixel {R5,G6,B5}
- pi_flag  in  1  rx_data valid this cycle
- pi_sof  in  1  first pixel of frame; qualified by pi_flag
- i_mode  in  2  0 passthrough, 1 grey, 2 Sobel magnitude, 3 binary; sampled on the SOF pixel
- i_thresh  in  8  binary threshold; sampled on the SOF pixel
- tx_data  out  16  RGB565 result pixel
- o_grey_data  out  16  grey of the current input pixel, RGB565-expanded, aligned with tx_data
- po_flag  out  1  tx_data / o_grey_data valid

## Operation
- Grey conversion:
  - Expand to 8 bits per channel: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y=(77*R8+150*G8+29*B8)>>8, with an unsigned 16-bit accumulator. White gives 255; black gives 0.
- Expansion of an 8-bit value m to RGB565: {m[7:3],m[7:2],m[7:3]}.
- Counters and frame sampling:
  - The column counter increments on every accepted pixel and wraps from IMG_W-1 to 0.
  - The row counter increments on the wrap and saturates at 2.
  - pi_flag&pi_sof forces that pixel to col=0,row=0.
  - The same pixel latches i_mode and i_thresh for the whole frame.
  - pi_sof without pi_flag is ignored.
- Line buffers:
  - Two rows of grey are stored.
  - Each accepted pixel reads column col and writes the new grey value at the same address, shifting the rows.
  - Line-buffer contents are never reset.
- Window:
  - A 3x3 shift register advances only on accepted pixels.
  - The result of an accepted pixel at (row,col) is centred on (row-1,col-1).
  - Border rule: if row<2 or col<2, the Sobel magnitude is forced to 0.
- Sobel arithmetic:
  - Gx and Gy use the standard kernels and are held as signed 11-bit values.
  - mag=|Gx|+|Gy|, saturated to 255.
- Mode outputs:
  - Mode 0: tx_data=rx_data of the current pixel.
  - Mode 1: tx_data=expand(Y) of the current pixel.
  - Mode 2: tx_data=expand(mag).
  - Mode 3: tx_data=0xFFFF if mag>thresh, else 0x0000.
  - Modes 0/1 carry no spatial shift. Modes 2/3 are shifted by one row and one column.
- o_grey_data is always expand(Y) of the current pixel, whatever the mode.
- The pipeline never stalls. Idle cycles propagate a cleared valid bit and do not move the window, counters or buffers.

## Timing
- Fixed latency: po_flag rises exactly 4 sclk edges after the edge that samples pi_flag=1. Pipeline stages:
  - S1: register input; compute Y.
  - S2: line-buffer read and window shift.
  - S3: Gx/Gy.
  - S4: magnitude, mode mux and output register.
- Throughput is one pixel per cycle.
- Count rule: the number of po_flag pulses equals the number of pi_flag pulses, and output order equals input order.
- Reset values: tx_data=0, o_grey_data=0, po_flag=0; counters 0; mode=0; thresh=0; valid pipeline cleared. These take effect asynchronously on rst rise.
- Reset mid-frame:
  - Pixels in flight are discarded.
  - The first accepted pixel after release is treated as row 0, col 0, with or without pi_sof.
  - Modes 2/3 therefore output 0 for the first 2*IMG_W pixels.
- Back-to-back SOF: an SOF before the end of a line restarts the counters. The partial line is not flushed.

## Structure
- Package sobel_edge_pkg holds:
  - the mode encoding constants (MODE_PASS, MODE_GREY, MODE_MAG, MODE_BIN);
  - the grey coefficients 77/150/29;
  - functions rgb565_to_y8 and y8_to_rgb565.
- Sub-module sobel_line_buf: simple dual-port RAM, IMG_W deep x 16 bits (two grey rows packed), one-cycle read latency, read and write at the same address in the same cycle returning old data.

## Test plan
- IMG_W=8, uniform frame of 0xFFFF:
  - mode 2: every output is 0x0000.
  - mode 0: every output is 0xFFFF, with po_flag 4 cycles after each pi_flag.
- IMG_W=8, cols 0-3 = 0x0000, cols 4-7 = 0xFFFF, mode 2: the input pixels at cols 4 and 5 give 0xFFFF for every row>=2 (mag 1020 saturated); all other outputs are 0x0000.
- Same frame in mode 3:
  - thresh=254: the same pattern as mode 2.
  - thresh=255: all outputs 0x0000.
- Same frame with random 0-3-cycle gaps between pi_flag pulses: the tx_data sequence is identical to the gap-free run, and the po_flag count equals the pi_flag count.
- i_mode changed 2->1 mid-frame: the output stays in mode 2 until the next pi_sof&pi_flag pixel; o_grey_data stays expand(Y) throughout (white gives 0xFFFF).
- rst pulsed for 3 cycles mid-frame:
  - po_flag, tx_data and o_grey_data read 0 in the same cycle as the rst rise.
  - After release, mode 0 applies and passes the input through.
  - After re-selecting mode 2 with an SOF, the first 16 outputs are 0x0000.
